// File: rtl/crc8_pkg.sv
// Shared CRC-8 definitions: default polynomial, FSM state encodings and the
// single-bit LFSR step used by both the generator and the checker.
package crc8_pkg;

  localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;

  // FSM state encodings (2-bit constants)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_CRC  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // One MSB-first LFSR step: feedback is the outgoing MSB xor the new bit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                           input logic       data_bit,
                                           input logic [7:0] poly);
    logic fb;
    fb = crc[7] ^ data_bit;
    return {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_lfsr.sv
// Registered 8-bit CRC LFSR with load/step/hold control. Also exposes the
// value the register would take on a step so callers can act on it early.
module crc8_lfsr
  import crc8_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY_DEFAULT,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       step,
  input  logic       data_in,
  output logic [7:0] crc,
  output logic [7:0] crc_next
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  // Next-state selection: load wins over step, otherwise hold.
  always_comb begin
    crc_next = crc8_step(crc_q, data_in, POLY);
    crc_d    = crc_q;
    if (load) begin
      crc_d = INIT;
    end else if (step) begin
      crc_d = crc_next;
    end else begin
      crc_d = crc_q;
    end
  end

  // LFSR register with synchronous active-low reset to the preset value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_q <= INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/crc8_checker.sv
// Serial CRC-8 receive checker. Runs DATA_BITS payload bits and then the
// 8 received CRC bits (MSB first) through one LFSR; an intact frame leaves
// a zero remainder. All outputs are registered.
module crc8_checker
  import crc8_pkg::*;
#(
  parameter int         DATA_BITS = 8,
  parameter logic [7:0] POLY      = CRC8_POLY_DEFAULT,
  parameter logic [7:0] INIT      = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       data_in,
  input  logic       enable,
  output logic       busy,
  output logic [7:0] crc_out,
  output logic       done,
  output logic       crc_ok,
  output logic       crc_err
);

  // Counter must reach DATA_BITS-1 and also 7 for the CRC phase.
  localparam int CNT_W = ($clog2(DATA_BITS + 1) < 4) ? 4 : $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_CRC  = CNT_W'(7);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  logic [1:0]       state_q,   state_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic [7:0]       crc_out_q, crc_out_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             ok_q,      ok_d;
  logic             err_q,     err_d;

  logic             lfsr_load;
  logic             lfsr_step;
  logic [7:0]       lfsr_val;
  logic [7:0]       lfsr_next;

  crc8_lfsr #(
    .POLY (POLY),
    .INIT (INIT)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lfsr_load),
    .step     (lfsr_step),
    .data_in  (data_in),
    .crc      (lfsr_val),
    .crc_next (lfsr_next)
  );

  // Frame FSM: phase sequencing, bit counting and verdict capture.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    crc_out_d = crc_out_q;
    ok_d      = ok_q;
    err_d     = err_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          lfsr_load = 1'b1;
          count_d   = CNT_ZERO;
          ok_d      = 1'b0;
          err_d     = 1'b0;
          state_d   = ST_DATA;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (enable) begin
          lfsr_step = 1'b1;
          if (count_q == LAST_DATA) begin
            // Payload-only CRC is frozen here; the CRC bits keep stepping.
            crc_out_d = lfsr_next;
            count_d   = CNT_ZERO;
            state_d   = ST_CRC;
          end else begin
            count_d   = count_q + CNT_ONE;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_CRC: begin
        if (enable) begin
          lfsr_step = 1'b1;
          if (count_q == LAST_CRC) begin
            ok_d    = (lfsr_next == 8'h00);
            err_d   = (lfsr_next != 8'h00);
            count_d = CNT_ZERO;
            state_d = ST_DONE;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end else begin
          state_d = ST_CRC;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_DATA) || (state_d == ST_CRC);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= CNT_ZERO;
      crc_out_q <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      crc_out_q <= crc_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
    end
  end

  assign busy    = busy_q;
  assign crc_out = crc_out_q;
  assign done    = done_q;
  assign crc_ok  = ok_q;
  assign crc_err = err_q;

endmodule

// File: tb/tb_crc8_checker.sv
// Directed, table-driven bench for crc8_checker (DATA_BITS=8, POLY=07, INIT=00).
module tb_crc8_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       data_in;
  logic       enable;
  logic       busy;
  logic [7:0] crc_out;
  logic       done;
  logic       crc_ok;
  logic       crc_err;

  int n_cmp;
  int n_bad;

  typedef struct {
    string      name;
    logic [7:0] payload;
    logic [7:0] crc;
    bit         gaps;
    int         start_at;
    logic [7:0] exp_crc_out;
    logic       exp_ok;
    logic       exp_err;
  } vec_t;

  vec_t vecs[7];

  crc8_checker dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .data_in (data_in),
    .enable  (enable),
    .busy    (busy),
    .crc_out (crc_out),
    .done    (done),
    .crc_ok  (crc_ok),
    .crc_err (crc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Sends one full frame (payload then CRC, MSB first) and checks the result.
  task automatic run_frame(input vec_t v);
    logic [15:0] frame;
    logic        early_done;
    frame      = {v.payload, v.crc};
    early_done = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({v.name, ":busy_after_start"}, busy, 1'b1);
    chk({v.name, ":ok_cleared"}, crc_ok, 1'b0);
    chk({v.name, ":err_cleared"}, crc_err, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (v.gaps && (i == 2 || i == 9 || i == 15)) begin
        for (int g = 0; g < 3; g++) begin
          enable  = 1'b0;
          data_in = ~frame[15-i];
          tick();
          chk({v.name, ":busy_in_gap"}, busy, 1'b1);
        end
      end
      data_in = frame[15-i];
      enable  = 1'b1;
      start   = (i == v.start_at);
      tick();
      enable  = 1'b0;
      start   = 1'b0;
      data_in = 1'b0;
      if (i < 15 && done) early_done = 1'b1;
      if (i == 7) chk({v.name, ":crc_out"}, crc_out, v.exp_crc_out);
    end
    chk({v.name, ":no_early_done"}, early_done, 1'b0);
    chk({v.name, ":done_pulse"}, done, 1'b1);
    chk({v.name, ":crc_ok"}, crc_ok, v.exp_ok);
    chk({v.name, ":crc_err"}, crc_err, v.exp_err);
    chk({v.name, ":busy_at_done"}, busy, 1'b0);
    tick();
    chk({v.name, ":done_one_cycle"}, done, 1'b0);
    chk({v.name, ":ok_held"}, crc_ok, v.exp_ok);
    chk({v.name, ":err_held"}, crc_err, v.exp_err);
    chk({v.name, ":crc_out_held"}, crc_out, v.exp_crc_out);
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    data_in = 1'b0;
    enable  = 1'b0;

    // name, payload, crc, gaps, start_at, crc_out, ok, err
    vecs[0] = '{"good55",   8'h55, 8'hAC, 1'b0, -1, 8'hAC, 1'b1, 1'b0};
    vecs[1] = '{"badcrc",   8'h55, 8'hAD, 1'b0, -1, 8'hAC, 1'b0, 1'b1};
    vecs[2] = '{"good0f",   8'h0F, 8'h2D, 1'b0, -1, 8'h2D, 1'b1, 1'b0};
    vecs[3] = '{"badpay",   8'h45, 8'hAC, 1'b0, -1, 8'hDC, 1'b0, 1'b1};
    vecs[4] = '{"gapped",   8'h55, 8'hAC, 1'b1, -1, 8'hAC, 1'b1, 1'b0};
    vecs[5] = '{"startign", 8'h55, 8'hAC, 1'b0,  4, 8'hAC, 1'b1, 1'b0};
    vecs[6] = '{"zeros",    8'h00, 8'h00, 1'b0, -1, 8'h00, 1'b1, 1'b0};

    tick();
    tick();
    chk("rst:busy", busy, 1'b0);
    chk("rst:done", done, 1'b0);
    chk("rst:crc_ok", crc_ok, 1'b0);
    chk("rst:crc_err", crc_err, 1'b0);
    chk("rst:crc_out", crc_out, 8'h00);
    rst_n = 1'b1;
    tick();
    chk("idle:busy", busy, 1'b0);

    for (int k = 0; k < 7; k++) begin
      run_frame(vecs[k]);
      tick();
    end

    // Establish a nonzero crc_out so the reset clearing it is observable.
    run_frame(vecs[0]);

    // Reset after 5 payload bits abandons the frame.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data_in = vecs[0].payload[7-i];
      enable  = 1'b1;
      tick();
    end
    enable = 1'b0;
    chk("midrst:busy_before", busy, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("midrst:busy", busy, 1'b0);
    chk("midrst:crc_out", crc_out, 8'h00);
    chk("midrst:done", done, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      enable  = 1'b1;
      data_in = 1'b1;
      tick();
      chk("midrst:no_done", done, 1'b0);
      chk("midrst:idle", busy, 1'b0);
    end
    enable = 1'b0;
    run_frame(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
